// File: rtl/dest_writeback_tracker_if.sv
// ID/EXE boundary signals for dest_writeback_tracker: ID-side controls in,
// stage tags, pending mask, in-flight count and drain status out.
interface dest_writeback_tracker_if #(
   parameter int REG_W = 4
);
   logic [REG_W-1:0]      id_dest;
   logic                  id_wb_en;
   logic                  freeze;
   logic                  flush;
   logic                  mem_ready;
   logic                  drain_req;
   logic [REG_W-1:0]      exe_dest;
   logic [REG_W-1:0]      mem_dest;
   logic [REG_W-1:0]      wb_dest;
   logic                  exe_wb_en;
   logic                  mem_wb_en;
   logic                  wb_wb_en;
   logic [2**REG_W-1:0]   pending;
   logic [1:0]            in_flight;
   logic                  drained;

   modport master (
      output id_dest, id_wb_en, freeze, flush, mem_ready, drain_req,
      input  exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en,
             pending, in_flight, drained
   );

   modport slave (
      input  id_dest, id_wb_en, freeze, flush, mem_ready, drain_req,
      output exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en,
             pending, in_flight, drained
   );
endinterface

// File: rtl/dest_writeback_tracker.sv
// Tracks {dest, wb_en} of instructions in EXE/MEM(/WB) with stall, flush,
// memory-wait and drain handling. Define DEST_TRACK_WB_STAGE_EN to track WB.
//
// state    | meaning
// ST_RUN   | normal issue; drain_req starts a drain
// ST_DRAIN | issue blocked until tracked stages hold only bubbles
// ST_DONE  | one-cycle drained pulse, issue still blocked
module dest_writeback_tracker #(
   parameter int REG_W = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   dest_writeback_tracker_if.slave     bus
);
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic             issue_block;
   logic             stages_empty_d;
   logic [REG_W-1:0] exe_dest_q, exe_dest_d, mem_dest_q, mem_dest_d;
   logic             exe_en_q, exe_en_d, mem_en_q, mem_en_d;
`ifdef DEST_TRACK_WB_STAGE_EN
   logic [REG_W-1:0] wb_dest_q, wb_dest_d;
   logic             wb_en_q, wb_en_d;
`endif

   always_comb begin
      state_d     = state_q;
      issue_block = (state_q != ST_RUN);
      exe_dest_d  = exe_dest_q;
      exe_en_d    = exe_en_q;
      mem_dest_d  = mem_dest_q;
      mem_en_d    = mem_en_q;
`ifdef DEST_TRACK_WB_STAGE_EN
      wb_dest_d   = wb_dest_q;
      wb_en_d     = wb_en_q;
`endif
      if (bus.mem_ready) begin
`ifdef DEST_TRACK_WB_STAGE_EN
         wb_dest_d  = mem_dest_q;
         wb_en_d    = mem_en_q;
`endif
         mem_dest_d = exe_dest_q;
         mem_en_d   = exe_en_q;
         if (bus.freeze || bus.flush || issue_block) begin
            exe_dest_d = '0;
            exe_en_d   = 1'b0;
         end else begin
            exe_dest_d = bus.id_dest;
            exe_en_d   = bus.id_wb_en;
         end
      end

      stages_empty_d = (exe_dest_d == '0) && !exe_en_d &&
                       (mem_dest_d == '0) && !mem_en_d;
`ifdef DEST_TRACK_WB_STAGE_EN
      stages_empty_d = stages_empty_d && (wb_dest_d == '0) && !wb_en_d;
`endif

      // The drain FSM freezes together with the back end during a memory wait.
      if (bus.mem_ready) begin
         case (state_q)
            ST_RUN:   if (bus.drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (stages_empty_d) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         exe_dest_q <= '0;
         exe_en_q   <= 1'b0;
         mem_dest_q <= '0;
         mem_en_q   <= 1'b0;
`ifdef DEST_TRACK_WB_STAGE_EN
         wb_dest_q  <= '0;
         wb_en_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         exe_dest_q <= exe_dest_d;
         exe_en_q   <= exe_en_d;
         mem_dest_q <= mem_dest_d;
         mem_en_q   <= mem_en_d;
`ifdef DEST_TRACK_WB_STAGE_EN
         wb_dest_q  <= wb_dest_d;
         wb_en_q    <= wb_en_d;
`endif
      end
   end

   always_comb begin
      bus.pending = '0;
      if (exe_en_q) bus.pending[exe_dest_q] = 1'b1;
      if (mem_en_q) bus.pending[mem_dest_q] = 1'b1;
`ifdef DEST_TRACK_WB_STAGE_EN
      if (wb_en_q)  bus.pending[wb_dest_q]  = 1'b1;
`endif
   end

`ifdef DEST_TRACK_WB_STAGE_EN
   assign bus.in_flight = {1'b0, exe_en_q} + {1'b0, mem_en_q} + {1'b0, wb_en_q};
   assign bus.wb_dest   = wb_dest_q;
   assign bus.wb_wb_en  = wb_en_q;
`else
   assign bus.in_flight = {1'b0, exe_en_q} + {1'b0, mem_en_q};
   assign bus.wb_dest   = '0;
   assign bus.wb_wb_en  = 1'b0;
`endif

   assign bus.exe_dest  = exe_dest_q;
   assign bus.exe_wb_en = exe_en_q;
   assign bus.mem_dest  = mem_dest_q;
   assign bus.mem_wb_en = mem_en_q;
   assign bus.drained   = (state_q == ST_DONE);
endmodule

// File: tb/tb_dest_writeback_tracker.sv
// Self-checking bench for dest_writeback_tracker: directed vectors, a
// queue-style pipeline model compared every cycle, plus literal checks.
module tb_dest_writeback_tracker;
`ifdef DEST_TRACK_WB_STAGE_EN
   localparam int NT = 3;
`else
   localparam int NT = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dest_writeback_tracker_if #(.REG_W(4)) bus ();
   dest_writeback_tracker #(.REG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB; mode 0=running, 1=draining, 2=done.
   logic [3:0] md [3];
   logic       me [3];
   int         mode = 0;

   always @(posedge clk) begin
      bit empty;
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin md[i] = '0; me[i] = 1'b0; end
         mode = 0;
      end else if (bus.mem_ready) begin
         md[2] = md[1]; me[2] = me[1];
         md[1] = md[0]; me[1] = me[0];
         if (bus.freeze || bus.flush || mode != 0) begin
            md[0] = '0; me[0] = 1'b0;
         end else begin
            md[0] = bus.id_dest; me[0] = bus.id_wb_en;
         end
         empty = 1'b1;
         for (int i = 0; i < NT; i++) if (md[i] != 0 || me[i]) empty = 1'b0;
         if (mode == 0) mode = bus.drain_req ? 1 : 0;
         else if (mode == 1) mode = empty ? 2 : 1;
         else mode = 0;
      end
   end

   always @(negedge clk) begin
      logic [15:0] p;
      int cnt;
      if (started) begin
         p = '0; cnt = 0;
         for (int i = 0; i < NT; i++) if (me[i]) begin p[md[i]] = 1'b1; cnt++; end
         chk("m_exe_dest", bus.exe_dest, md[0]);
         chk("m_exe_en",   bus.exe_wb_en, me[0]);
         chk("m_mem_dest", bus.mem_dest, md[1]);
         chk("m_mem_en",   bus.mem_wb_en, me[1]);
`ifdef DEST_TRACK_WB_STAGE_EN
         chk("m_wb_dest",  bus.wb_dest, md[2]);
         chk("m_wb_en",    bus.wb_wb_en, me[2]);
`else
         chk("m_wb_dest",  bus.wb_dest, 0);
         chk("m_wb_en",    bus.wb_wb_en, 0);
`endif
         chk("m_pending",  bus.pending, p);
         chk("m_in_flight", bus.in_flight, cnt);
         chk("m_drained",  bus.drained, mode == 2);
      end
   end

   task automatic step(input logic [3:0] d, input logic en, input logic fz = 0,
                       input logic fl = 0, input logic mr = 1, input logic dr = 0);
      bus.id_dest = d; bus.id_wb_en = en; bus.freeze = fz;
      bus.flush = fl; bus.mem_ready = mr; bus.drain_req = dr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_pending"}, bus.pending, 0);
      chk({name, "_in_flight"}, bus.in_flight, 0);
      chk({name, "_exe_en"}, bus.exe_wb_en, 0);
      chk({name, "_exe_dest"}, bus.exe_dest, 0);
      chk({name, "_mem_en"}, bus.mem_wb_en, 0);
      chk({name, "_wb_en"}, bus.wb_wb_en, 0);
      chk({name, "_drained"}, bus.drained, 0);
   endtask

   initial begin
      bit seen;
      bus.id_dest = '0; bus.id_wb_en = 0; bus.freeze = 0;
      bus.flush = 0; bus.mem_ready = 1; bus.drain_req = 0;
      rst = 1'b0;
      step(0, 0);
      step(0, 0);
      started = 1'b1;
      chk_zero("reset");
      rst = 1'b1;

      // Pipeline advance
      step(5, 1);
      chk("adv_exe_dest", bus.exe_dest, 5);
      chk("adv_pending1", bus.pending, 16'h0020);
      chk("adv_in_flight1", bus.in_flight, 1);
      step(0, 0);
      chk("adv_mem_dest", bus.mem_dest, 5);
      step(0, 0);
`ifdef DEST_TRACK_WB_STAGE_EN
      chk("adv_wb_dest", bus.wb_dest, 5);
      chk("adv_pending3", bus.pending, 16'h0020);
`else
      chk("adv_pending3", bus.pending, 0);
`endif
      step(0, 0);

      // Stall and flush
      step(3, 1, 1, 0);
      chk("freeze_exe_en", bus.exe_wb_en, 0);
      step(4, 1, 0, 1);
      chk("flush_exe_en", bus.exe_wb_en, 0);
      chk("flush_pending", bus.pending, 0);
      step(6, 1, 1, 1);
      chk("ff_exe_en", bus.exe_wb_en, 0);
      step(8, 1);
      chk("ff_next_exe", bus.exe_dest, 8);
      chk("ff_next_pend", bus.pending, 16'h0100);

      // Memory wait
      step(0, 0); step(0, 0); step(0, 0);
      step(2, 1);
      step(1, 1);
      for (int i = 0; i < 3; i++) begin
         step(9, 1, 0, 0, 0, 1);
         chk("mw_pending", bus.pending, 16'h0006);
         chk("mw_exe_dest", bus.exe_dest, 1);
         chk("mw_mem_dest", bus.mem_dest, 2);
      end
      step(0, 0);
      chk("mw_resume_mem", bus.mem_dest, 1);
      chk("mw_resume_exe", bus.exe_wb_en, 0);

      // Duplicate destinations
      step(7, 1); step(7, 1); step(7, 1);
      chk("dup_pending", bus.pending, 16'h0080);
      chk("dup_in_flight", bus.in_flight, NT);
      step(9, 0);
      chk("dup_bit9_clear", bus.pending[9], 0);
      chk("dup_pending2", bus.pending, 16'h0080);

      // Drain with two writes in flight
      step(0, 0); step(0, 0); step(0, 0);
      step(10, 1); step(11, 1);
      chk("drain_pre_inflight", bus.in_flight, 2);
      step(0, 0, 0, 0, 1, 1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(12, 1);
         chk("drain_blocked", bus.exe_wb_en, 0);
         if (bus.drained) seen = 1'b1;
      end
      chk("drain_seen", seen, 1);
      chk("drain_pending0", bus.pending, 0);
      step(12, 1);
      chk("drain_pulse_end", bus.drained, 0);
      step(12, 1);
      chk("drain_issue_again", bus.exe_dest, 12);

      // Reset mid-drain
      step(3, 1);
      step(0, 0, 0, 0, 1, 1);
      rst = 1'b0;
      step(0, 0);
      chk_zero("rst_drain");
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(0, 0);
         chk("rst_no_pulse", bus.drained, 0);
      end

      // Held drain_req re-enters through RUN
      step(4, 1);
      for (int i = 0; i < 8; i++) step(5, 1, 0, 0, 1, 1);
      step(0, 0); step(0, 0); step(0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
